mmu_tlb: RTL and testbench

- Joint TLB next to CP0; it consumes CP0's Index, EntryHi, EntryLo0 and EntryLo1 values.
- Translates instruction-fetch and data virtual addresses to physical addresses.
- Raises TLB exception codes that the MEM stage forwards to CP0 as the exc_code/badvaddr pair.
- Executes TLBP/TLBR/TLBWI/TLBWR and returns a registered write-back bundle to CP0.

---
 rtl/mmu_tlb_pkg.sv | 68 ++++++
 rtl/mmu_tlb_if.sv | 38 +++
 rtl/tlb_match.sv | 31 +++
 rtl/mmu_tlb.sv | 149 ++++++++++++++
 tb/tb_mmu_tlb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_tlb_pkg.sv
// Shared types and constants for the joint TLB: op encodings, exception codes,
// CP0 register field positions and the packed entry layout.
package mmu_tlb_pkg;

  localparam int DEF_TLB_ENTRIES = 16;
  localparam int DEF_IDX_W       = 4;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_TLBP  = 3'd1,
    OP_TLBR  = 3'd2,
    OP_TLBWI = 3'd3,
    OP_TLBWR = 3'd4
  } tlb_op_e;

  localparam logic [4:0] EC_NONE    = 5'h1f;
  localparam logic [4:0] EC_TLB_MOD = 5'h01;
  localparam logic [4:0] EC_TLBL    = 5'h02;
  localparam logic [4:0] EC_TLBS    = 5'h03;

  localparam int HI_VPN2_LSB = 13;
  localparam int LO_PFN_LSB  = 6;
  localparam int LO_C_LSB    = 3;
  localparam int LO_D_BIT    = 2;
  localparam int LO_V_BIT    = 1;
  localparam int LO_G_BIT    = 0;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic [18:0]     vpn2;
    logic [7:0]      asid;
    logic            g;
    tlb_page_t [1:0] page;
  } tlb_entry_t;

  function automatic tlb_page_t lo_to_page(input logic [31:0] lo);
    tlb_page_t p;
    p.pfn = lo[LO_PFN_LSB +: 20];
    p.c   = lo[LO_C_LSB +: 3];
    p.d   = lo[LO_D_BIT];
    p.v   = lo[LO_V_BIT];
    return p;
  endfunction

  // Global only when both halves agree, matching the R4000 convention.
  function automatic tlb_entry_t make_entry(input logic [31:0] hi,
                                            input logic [31:0] lo0,
                                            input logic [31:0] lo1);
    tlb_entry_t e;
    e.vpn2    = hi[HI_VPN2_LSB +: 19];
    e.asid    = hi[7:0];
    e.g       = lo0[LO_G_BIT] & lo1[LO_G_BIT];
    e.page[0] = lo_to_page(lo0);
    e.page[1] = lo_to_page(lo1);
    return e;
  endfunction

  function automatic logic [31:0] page_to_lo(input tlb_page_t p, input logic g);
    return {6'b0, p.pfn, p.c, p.d, p.v, g};
  endfunction

endpackage

// File: rtl/mmu_tlb_if.sv
// Bundle of CP0 op/data signals and the two translation ports of the TLB.
interface mmu_tlb_if #(parameter int IDX_W = 4);
  logic [2:0]       tlb_op_i;
  logic [31:0]      index_i;
  logic [31:0]      entry_hi_i;
  logic [31:0]      entry_lo0_i;
  logic [31:0]      entry_lo1_i;
  logic [31:0]      iaddr_i;
  logic             ireq_i;
  logic [31:0]      ipaddr_o;
  logic [4:0]       iexc_o;
  logic [31:0]      daddr_i;
  logic             dreq_i;
  logic             dwe_i;
  logic [31:0]      dpaddr_o;
  logic [4:0]       dexc_o;
  logic [IDX_W-1:0] random_o;
  logic             idx_we_o;
  logic [31:0]      index_o;
  logic             ent_we_o;
  logic [31:0]      entry_hi_o;
  logic [31:0]      entry_lo0_o;
  logic [31:0]      entry_lo1_o;

  modport master (
    output tlb_op_i, index_i, entry_hi_i, entry_lo0_i, entry_lo1_i,
    output iaddr_i, ireq_i, daddr_i, dreq_i, dwe_i,
    input  ipaddr_o, iexc_o, dpaddr_o, dexc_o, random_o,
    input  idx_we_o, index_o, ent_we_o, entry_hi_o, entry_lo0_o, entry_lo1_o
  );

  modport slave (
    input  tlb_op_i, index_i, entry_hi_i, entry_lo0_i, entry_lo1_i,
    input  iaddr_i, ireq_i, daddr_i, dreq_i, dwe_i,
    output ipaddr_o, iexc_o, dpaddr_o, dexc_o, random_o,
    output idx_we_o, index_o, ent_we_o, entry_hi_o, entry_lo0_o, entry_lo1_o
  );
endinterface

// File: rtl/tlb_match.sv
// Fully associative VPN2/ASID compare over all entries; lowest matching index wins.
module tlb_match
  import mmu_tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = DEF_TLB_ENTRIES,
  parameter int IDX_W       = DEF_IDX_W
) (
  input  tlb_entry_t [TLB_ENTRIES-1:0] entries,
  input  logic [18:0]                  vpn2,
  input  logic [7:0]                   asid,
  input  logic                         odd,
  output logic                         hit,
  output logic [IDX_W-1:0]             idx,
  output tlb_page_t                    page
);

  // Scanning downward lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    page = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].vpn2 == vpn2 && (entries[i].g || entries[i].asid == asid)) begin
        hit  = 1'b1;
        idx  = IDX_W'(i);
        page = entries[i].page[odd];
      end
    end
  end

endmodule

// File: rtl/mmu_tlb.sv
// Joint TLB: combinational fetch/data translation plus TLBP/TLBR/TLBWI/TLBWR
// with a registered write-back bundle for CP0.
module mmu_tlb
  import mmu_tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = DEF_TLB_ENTRIES,
  parameter int IDX_W       = DEF_IDX_W
) (
  input logic       clk,
  input logic       rst,
  mmu_tlb_if.slave  bus
);

  tlb_entry_t [TLB_ENTRIES-1:0] entries_reg;
  logic [IDX_W-1:0]             random_reg;
  logic                         idx_we_reg;
  logic                         ent_we_reg;
  logic [31:0]                  index_reg;
  logic [31:0]                  entry_hi_reg;
  logic [31:0]                  entry_lo0_reg;
  logic [31:0]                  entry_lo1_reg;

  tlb_op_e          op;
  logic [IDX_W-1:0] op_idx;
  logic [IDX_W-1:0] wr_idx;
  tlb_entry_t       wr_entry;
  tlb_entry_t       rd_entry;
  logic             unused_bits;

  always_comb begin
    op = OP_NONE;
    case (bus.tlb_op_i)
      3'd1, 3'd2, 3'd3, 3'd4: op = tlb_op_e'(bus.tlb_op_i);
      default:                op = OP_NONE;
    endcase
  end

  assign op_idx   = bus.index_i[IDX_W-1:0];
  assign wr_idx   = (op == OP_TLBWR) ? random_reg : op_idx;
  assign wr_entry = make_entry(bus.entry_hi_i, bus.entry_lo0_i, bus.entry_lo1_i);
  assign rd_entry = entries_reg[op_idx];

  // Match instances: 0 = fetch, 1 = data, 2 = probe (page half irrelevant).
  for (genvar gi = 0; gi < 3; gi++) begin : g_match
    logic [18:0]      vpn2;
    logic             odd;
    logic             hit;
    logic [IDX_W-1:0] idx;
    tlb_page_t        page;

    assign vpn2 = (gi == 0) ? bus.iaddr_i[31:13] :
                  (gi == 1) ? bus.daddr_i[31:13] : bus.entry_hi_i[31:13];
    assign odd  = (gi == 0) ? bus.iaddr_i[12] :
                  (gi == 1) ? bus.daddr_i[12] : 1'b0;

    tlb_match #(
      .TLB_ENTRIES (TLB_ENTRIES),
      .IDX_W       (IDX_W)
    ) u_match (
      .entries (entries_reg),
      .vpn2    (vpn2),
      .asid    (bus.entry_hi_i[7:0]),
      .odd     (odd),
      .hit     (hit),
      .idx     (idx),
      .page    (page)
    );
  end

  // Translation ports: 0 = fetch (never a store), 1 = data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_xlate
    logic [31:0] vaddr;
    logic        req;
    logic        store;
    logic [31:0] paddr;
    logic [4:0]  exc;

    assign vaddr = (gi == 0) ? bus.iaddr_i : bus.daddr_i;
    assign req   = (gi == 0) ? bus.ireq_i  : bus.dreq_i;
    assign store = (gi == 0) ? 1'b0        : bus.dwe_i;

    always_comb begin
      paddr = '0;
      exc   = EC_NONE;
      if (req) begin
        if (vaddr[31:30] == 2'b10) begin
          // kseg0/kseg1 bypass the TLB entirely.
          paddr = vaddr & 32'h1FFF_FFFF;
        end else if (!g_match[gi].hit || !g_match[gi].page.v) begin
          exc = store ? EC_TLBS : EC_TLBL;
        end else if (store && !g_match[gi].page.d) begin
          exc = EC_TLB_MOD;
        end else begin
          paddr = {g_match[gi].page.pfn, vaddr[11:0]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_reg   <= '0;
      random_reg    <= IDX_W'(TLB_ENTRIES - 1);
      idx_we_reg    <= 1'b0;
      ent_we_reg    <= 1'b0;
      index_reg     <= '0;
      entry_hi_reg  <= '0;
      entry_lo0_reg <= '0;
      entry_lo1_reg <= '0;
    end else begin
      idx_we_reg <= 1'b0;
      ent_we_reg <= 1'b0;
      if (op != OP_TLBWR) begin
        random_reg <= (random_reg == '0) ? IDX_W'(TLB_ENTRIES - 1) : random_reg - 1'b1;
      end
      case (op)
        OP_TLBWI, OP_TLBWR: entries_reg[wr_idx] <= wr_entry;
        OP_TLBP: begin
          idx_we_reg <= 1'b1;
          index_reg  <= g_match[2].hit ? {{(32-IDX_W){1'b0}}, g_match[2].idx}
                                       : 32'h8000_0000;
        end
        OP_TLBR: begin
          ent_we_reg    <= 1'b1;
          entry_hi_reg  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
          entry_lo0_reg <= page_to_lo(rd_entry.page[0], rd_entry.g);
          entry_lo1_reg <= page_to_lo(rd_entry.page[1], rd_entry.g);
        end
        default: ;
      endcase
    end
  end

  assign bus.ipaddr_o    = g_xlate[0].paddr;
  assign bus.iexc_o      = g_xlate[0].exc;
  assign bus.dpaddr_o    = g_xlate[1].paddr;
  assign bus.dexc_o      = g_xlate[1].exc;
  assign bus.random_o    = random_reg;
  assign bus.idx_we_o    = idx_we_reg;
  assign bus.index_o     = index_reg;
  assign bus.ent_we_o    = ent_we_reg;
  assign bus.entry_hi_o  = entry_hi_reg;
  assign bus.entry_lo0_o = entry_lo0_reg;
  assign bus.entry_lo1_o = entry_lo1_reg;

  assign unused_bits = ^{bus.index_i[31:IDX_W], g_match[0].idx, g_match[1].idx,
                         g_match[2].page};

endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb: directed scenarios plus randomized ops
// compared against a word-level model of the TLB contents.
module tb_mmu_tlb;
  import mmu_tlb_pkg::*;

  localparam int TLB_N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails = 0;

  mmu_tlb_if #(.IDX_W(4)) bus ();

  mmu_tlb u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: raw CP0 words per entry plus the combined global bit.
  logic [31:0] m_hi [TLB_N];
  logic [31:0] m_lo [TLB_N][2];
  logic        m_g  [TLB_N];
  int          m_random;
  logic        exp_idx_we, exp_ent_we;
  logic [31:0] exp_index, exp_ehi, exp_elo0, exp_elo1;
  logic [18:0] vpn_pool [6];

  function automatic int m_find(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int i = 0; i < TLB_N; i++)
      if (m_hi[i][31:13] == vpn2 && (m_g[i] || m_hi[i][7:0] == asid)) return i;
    return -1;
  endfunction

  function automatic void model_xlate(input logic [31:0] va, input logic req, input logic store,
                                      input logic [7:0] asid,
                                      output logic [31:0] pa, output logic [4:0] ec);
    int e;
    logic [31:0] lo;
    pa = 32'h0;
    ec = EC_NONE;
    if (!req) return;
    if (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) begin
      pa = va - (va >= 32'hA000_0000 ? 32'hA000_0000 : 32'h8000_0000);
      return;
    end
    e = m_find(va[31:13], asid);
    if (e < 0) begin
      ec = store ? EC_TLBS : EC_TLBL;
      return;
    end
    lo = m_lo[e][va[12]];
    if (!lo[1]) ec = store ? EC_TLBS : EC_TLBL;
    else if (store && !lo[2]) ec = EC_TLB_MOD;
    else pa = (lo >> 6) * 4096 + (va % 4096);
  endfunction

  task automatic model_clock(input logic [2:0] op);
    int hit, wi;
    if (rst) begin
      for (int i = 0; i < TLB_N; i++) begin
        m_hi[i] = 0; m_lo[i][0] = 0; m_lo[i][1] = 0; m_g[i] = 0;
      end
      m_random = TLB_N - 1;
      exp_idx_we = 0; exp_ent_we = 0;
      exp_index = 0; exp_ehi = 0; exp_elo0 = 0; exp_elo1 = 0;
    end else begin
      exp_idx_we = 0;
      exp_ent_we = 0;
      if (op == 3'd1) begin
        hit = m_find(bus.entry_hi_i[31:13], bus.entry_hi_i[7:0]);
        exp_idx_we = 1;
        exp_index = (hit < 0) ? 32'h8000_0000 : 32'(hit);
      end else if (op == 3'd2) begin
        wi = int'(bus.index_i % TLB_N);
        exp_ent_we = 1;
        exp_ehi  = m_hi[wi] & 32'hFFFF_E0FF;
        exp_elo0 = {6'b0, m_lo[wi][0][25:1], m_g[wi]};
        exp_elo1 = {6'b0, m_lo[wi][1][25:1], m_g[wi]};
      end else if (op == 3'd3 || op == 3'd4) begin
        wi = (op == 3'd3) ? int'(bus.index_i % TLB_N) : m_random;
        m_hi[wi] = bus.entry_hi_i;
        m_lo[wi][0] = bus.entry_lo0_i;
        m_lo[wi][1] = bus.entry_lo1_i;
        m_g[wi] = bus.entry_lo0_i[0] & bus.entry_lo1_i[0];
      end
      if (op != 3'd4) m_random = (m_random + TLB_N - 1) % TLB_N;
    end
  endtask

  task automatic step(input logic [2:0] op);
    bus.tlb_op_i = op;
    @(posedge clk);
    model_clock(op);
    #1;
    bus.tlb_op_i = 3'd0;
  endtask

  task automatic set_op_data(input logic [31:0] idx, input logic [31:0] hi,
                             input logic [31:0] lo0, input logic [31:0] lo1);
    bus.index_i = idx; bus.entry_hi_i = hi; bus.entry_lo0_i = lo0; bus.entry_lo1_i = lo1;
  endtask

  task automatic drive_lookup(input logic [31:0] ia, input logic ir, input logic [31:0] da,
                              input logic dr, input logic dw, input logic [7:0] asid);
    bus.iaddr_i = ia; bus.ireq_i = ir;
    bus.daddr_i = da; bus.dreq_i = dr; bus.dwe_i = dw;
    bus.entry_hi_i = {24'h0, asid};
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(3'd0);
    step(3'd0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.random_o !== 4'd15) begin fails++; $display("FAIL rst_random got=%0d exp=15", bus.random_o); end
    checks++;
    if ({bus.idx_we_o, bus.ent_we_o} !== 2'b00) begin fails++; $display("FAIL rst_pulses got=%b exp=00", {bus.idx_we_o, bus.ent_we_o}); end
    checks++;
    if ({bus.index_o, bus.entry_hi_o, bus.entry_lo0_o, bus.entry_lo1_o} !== 128'h0) begin
      fails++; $display("FAIL rst_data got=%h %h %h %h exp=0", bus.index_o, bus.entry_hi_o, bus.entry_lo0_o, bus.entry_lo1_o);
    end
    drive_lookup(32'h0040_0000, 1'b1, 32'h8000_1234, 1'b1, 1'b0, 8'h00);
    checks++;
    if (bus.iexc_o !== EC_TLBL || bus.ipaddr_o !== 32'h0) begin
      fails++; $display("FAIL rst_fetch_miss got=%h/%h exp=%h/0", bus.iexc_o, bus.ipaddr_o, EC_TLBL);
    end
    checks++;
    if (bus.dexc_o !== EC_NONE || bus.dpaddr_o !== 32'h0000_1234) begin
      fails++; $display("FAIL rst_unmapped got=%h/%h exp=%h/00001234", bus.dexc_o, bus.dpaddr_o, EC_NONE);
    end
    $display("test_reset done");
  endtask

  task automatic test_random_count();
    for (int k = 1; k <= 16; k++) begin
      step(3'd0);
      checks++;
      if (bus.random_o !== 4'((15 - k) & 15)) begin
        fails++; $display("FAIL random_count step=%0d got=%0d exp=%0d", k, bus.random_o, (15 - k) & 15);
      end
    end
    $display("test_random_count done");
  endtask

  task automatic test_translate();
    set_op_data(32'd3, 32'h0040_0005, 32'h0000_1046, 32'h0000_1044);
    step(3'd3);
    drive_lookup(32'h0, 1'b0, 32'h0040_0ABC, 1'b1, 1'b0, 8'h05);
    checks++;
    if (bus.dexc_o !== EC_NONE || bus.dpaddr_o !== 32'h0004_1ABC) begin
      fails++; $display("FAIL tr_hit got=%h/%h exp=%h/00041abc", bus.dexc_o, bus.dpaddr_o, EC_NONE);
    end
    checks++;
    if (bus.iexc_o !== EC_NONE || bus.ipaddr_o !== 32'h0) begin
      fails++; $display("FAIL tr_noreq got=%h/%h exp=%h/0", bus.iexc_o, bus.ipaddr_o, EC_NONE);
    end
    drive_lookup(32'h0040_1000, 1'b1, 32'h0040_1000, 1'b1, 1'b0, 8'h05);
    checks++;
    if (bus.dexc_o !== EC_TLBL || bus.dpaddr_o !== 32'h0 || bus.iexc_o !== EC_TLBL) begin
      fails++; $display("FAIL tr_invalid_page got=%h/%h/%h exp=%h/0", bus.dexc_o, bus.dpaddr_o, bus.iexc_o, EC_TLBL);
    end
    drive_lookup(32'h0, 1'b0, 32'h0040_0ABC, 1'b1, 1'b0, 8'h06);
    checks++;
    if (bus.dexc_o !== EC_TLBL || bus.dpaddr_o !== 32'h0) begin
      fails++; $display("FAIL tr_asid got=%h/%h exp=%h/0", bus.dexc_o, bus.dpaddr_o, EC_TLBL);
    end
    drive_lookup(32'h0, 1'b0, 32'h0040_1000, 1'b1, 1'b1, 8'h05);
    checks++;
    if (bus.dexc_o !== EC_TLBS) begin fails++; $display("FAIL tr_store_miss got=%h exp=%h", bus.dexc_o, EC_TLBS); end
    $display("test_translate done");
  endtask

  task automatic test_probe();
    set_op_data(32'd0, 32'h0040_0005, 32'h0, 32'h0);
    step(3'd1);
    checks++;
    if (bus.idx_we_o !== 1'b1 || bus.index_o !== 32'd3) begin
      fails++; $display("FAIL probe_hit got=%b/%h exp=1/00000003", bus.idx_we_o, bus.index_o);
    end
    step(3'd0);
    checks++;
    if (bus.idx_we_o !== 1'b0 || bus.index_o !== 32'd3) begin
      fails++; $display("FAIL probe_hold got=%b/%h exp=0/00000003", bus.idx_we_o, bus.index_o);
    end
    set_op_data(32'd0, 32'h1000_0000, 32'h0, 32'h0);
    step(3'd1);
    checks++;
    if (bus.idx_we_o !== 1'b1 || bus.index_o !== 32'h8000_0000) begin
      fails++; $display("FAIL probe_miss got=%b/%h exp=1/80000000", bus.idx_we_o, bus.index_o);
    end
    $display("test_probe done");
  endtask

  task automatic test_tlbr();
    set_op_data(32'hFFFF_FFF3, 32'h0, 32'h0, 32'h0);
    step(3'd2);
    checks++;
    if (bus.ent_we_o !== 1'b1 || bus.entry_hi_o !== 32'h0040_0005 || bus.entry_lo0_o !== 32'h0000_1046
        || bus.entry_lo1_o !== 32'h0000_1044) begin
      fails++; $display("FAIL tlbr got=%b/%h/%h/%h exp=1/00400005/00001046/00001044",
                        bus.ent_we_o, bus.entry_hi_o, bus.entry_lo0_o, bus.entry_lo1_o);
    end
    step(3'd0);
    checks++;
    if (bus.ent_we_o !== 1'b0 || bus.entry_hi_o !== 32'h0040_0005) begin
      fails++; $display("FAIL tlbr_pulse got=%b/%h exp=0/00400005", bus.ent_we_o, bus.entry_hi_o);
    end
    $display("test_tlbr done");
  endtask

  task automatic test_store_protect();
    set_op_data(32'd3, 32'h0040_0005, 32'h0000_1042, 32'h0);
    step(3'd3);
    drive_lookup(32'h0, 1'b0, 32'h0040_0010, 1'b1, 1'b1, 8'h05);
    checks++;
    if (bus.dexc_o !== EC_TLB_MOD || bus.dpaddr_o !== 32'h0) begin
      fails++; $display("FAIL store_mod got=%h/%h exp=%h/0", bus.dexc_o, bus.dpaddr_o, EC_TLB_MOD);
    end
    drive_lookup(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 8'h05);
    checks++;
    if (bus.dexc_o !== EC_NONE || bus.dpaddr_o !== 32'h0004_1010 || bus.ipaddr_o !== 32'h0004_1010) begin
      fails++; $display("FAIL store_load got=%h/%h/%h exp=%h/00041010", bus.dexc_o, bus.dpaddr_o, bus.ipaddr_o, EC_NONE);
    end
    $display("test_store_protect done");
  endtask

  task automatic test_tlbwr();
    for (int k = 0; k < 2 * TLB_N && m_random != 7; k++) step(3'd0);
    checks++;
    if (bus.random_o !== 4'd7) begin fails++; $display("FAIL wr_pre_random got=%0d exp=7", bus.random_o); end
    set_op_data(32'd0, 32'h00C0_0011, 32'h0000_2087, 32'h0000_30C6);
    step(3'd4);
    checks++;
    if (bus.random_o !== 4'd7) begin fails++; $display("FAIL wr_frozen got=%0d exp=7", bus.random_o); end
    set_op_data(32'd7, 32'h0, 32'h0, 32'h0);
    step(3'd2);
    checks++;
    if (bus.ent_we_o !== 1'b1 || bus.entry_hi_o !== 32'h00C0_0011 || bus.entry_lo0_o !== 32'h0000_2086
        || bus.entry_lo1_o !== 32'h0000_30C6) begin
      fails++; $display("FAIL wr_readback got=%b/%h/%h/%h exp=1/00c00011/00002086/000030c6",
                        bus.ent_we_o, bus.entry_hi_o, bus.entry_lo0_o, bus.entry_lo1_o);
    end
    checks++;
    if (bus.random_o !== 4'd6) begin fails++; $display("FAIL wr_resume got=%0d exp=6", bus.random_o); end
    $display("test_tlbwr done");
  endtask

  task automatic test_back_to_back();
    set_op_data(32'd9, 32'h0123_4000, 32'h0000_0A47, 32'h0000_0B47);
    bus.daddr_i = 32'h0123_4008; bus.dreq_i = 1'b1; bus.dwe_i = 1'b0;
    bus.tlb_op_i = 3'd3;
    #1;
    checks++;
    if (bus.dexc_o !== EC_TLBL || bus.dpaddr_o !== 32'h0) begin
      fails++; $display("FAIL b2b_old_view got=%h/%h exp=%h/0", bus.dexc_o, bus.dpaddr_o, EC_TLBL);
    end
    step(3'd3);
    checks++;
    if (bus.dexc_o !== EC_NONE || bus.dpaddr_o !== 32'h0002_9008) begin
      fails++; $display("FAIL b2b_new_view got=%h/%h exp=%h/00029008", bus.dexc_o, bus.dpaddr_o, EC_NONE);
    end
    step(3'd2);
    checks++;
    if (bus.ent_we_o !== 1'b1 || bus.entry_hi_o !== 32'h0123_4000 || bus.entry_lo0_o !== 32'h0000_0A47
        || bus.entry_lo1_o !== 32'h0000_0B47) begin
      fails++; $display("FAIL b2b_tlbr got=%b/%h/%h/%h exp=1/01234000/00000a47/00000b47",
                        bus.ent_we_o, bus.entry_hi_o, bus.entry_lo0_o, bus.entry_lo1_o);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_random_ops();
    logic [31:0] va, vd, exp_pa;
    logic [4:0]  exp_ec;
    logic [7:0]  asid;
    int          sel;
    for (int i = 0; i < 6; i++) begin
      vpn_pool[i] = 19'($urandom);
      if (vpn_pool[i][18:17] == 2'b10) vpn_pool[i][18] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 99);
      asid = 8'($urandom_range(0, 3));
      if (sel < 40) begin
        va = {vpn_pool[$urandom_range(0, 5)], 13'($urandom)};
        vd = ($urandom_range(0, 7) == 0) ? {2'b10, 30'($urandom)} :
             ($urandom_range(0, 3) == 0) ? $urandom : {vpn_pool[$urandom_range(0, 5)], 13'($urandom)};
        drive_lookup(va, 1'($urandom), vd, 1'($urandom_range(0, 7) != 0), 1'($urandom), asid);
        model_xlate(bus.iaddr_i, bus.ireq_i, 1'b0, asid, exp_pa, exp_ec);
        checks++;
        if (bus.iexc_o !== exp_ec || bus.ipaddr_o !== exp_pa) begin
          fails++; $display("FAIL rnd_fetch va=%h got=%h/%h exp=%h/%h", va, bus.iexc_o, bus.ipaddr_o, exp_ec, exp_pa);
        end
        model_xlate(bus.daddr_i, bus.dreq_i, bus.dwe_i, asid, exp_pa, exp_ec);
        checks++;
        if (bus.dexc_o !== exp_ec || bus.dpaddr_o !== exp_pa) begin
          fails++; $display("FAIL rnd_data va=%h we=%b got=%h/%h exp=%h/%h", vd, bus.dwe_i, bus.dexc_o, bus.dpaddr_o, exp_ec, exp_pa);
        end
      end else begin
        set_op_data($urandom, {vpn_pool[$urandom_range(0, 5)], 5'($urandom), asid},
                    $urandom & 32'h03FF_FFFF, $urandom & 32'h03FF_FFFF);
        if (sel < 65)      step(3'd3);
        else if (sel < 75) step(3'd4);
        else if (sel < 88) step(3'd1);
        else if (sel < 96) step(3'd2);
        else               step(3'($urandom_range(5, 7)));
        checks++;
        if (bus.idx_we_o !== exp_idx_we || bus.ent_we_o !== exp_ent_we || bus.index_o !== exp_index
            || bus.random_o !== 4'(m_random)) begin
          fails++; $display("FAIL rnd_probe n=%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", n, bus.idx_we_o, bus.ent_we_o,
                            bus.index_o, bus.random_o, exp_idx_we, exp_ent_we, exp_index, m_random);
        end
        checks++;
        if (bus.entry_hi_o !== exp_ehi || bus.entry_lo0_o !== exp_elo0 || bus.entry_lo1_o !== exp_elo1) begin
          fails++; $display("FAIL rnd_read n=%0d got=%h/%h/%h exp=%h/%h/%h", n, bus.entry_hi_o, bus.entry_lo0_o,
                            bus.entry_lo1_o, exp_ehi, exp_elo0, exp_elo1);
        end
      end
    end
    $display("test_random_ops done");
  endtask

  task automatic test_reset_mid_op();
    set_op_data(32'd2, 32'h0040_0005, 32'h0000_1046, 32'h0000_1046);
    step(3'd3);
    step(3'd2);
    rst = 1'b1;
    set_op_data(32'd5, 32'h0080_0001, 32'h0000_0047, 32'h0000_0047);
    step(3'd3);
    rst = 1'b0;
    checks++;
    if (bus.ent_we_o !== 1'b0 || bus.entry_hi_o !== 32'h0 || bus.random_o !== 4'd15) begin
      fails++; $display("FAIL midrst_state got=%b/%h/%0d exp=0/0/15", bus.ent_we_o, bus.entry_hi_o, bus.random_o);
    end
    drive_lookup(32'h0080_0000, 1'b1, 32'h0040_0000, 1'b1, 1'b0, 8'h05);
    checks++;
    if (bus.iexc_o !== EC_TLBL || bus.dexc_o !== EC_TLBL) begin
      fails++; $display("FAIL midrst_cleared got=%h/%h exp=%h", bus.iexc_o, bus.dexc_o, EC_TLBL);
    end
    set_op_data(32'd5, 32'h0, 32'h0, 32'h0);
    step(3'd2);
    checks++;
    if (bus.ent_we_o !== 1'b1 || {bus.entry_hi_o, bus.entry_lo0_o, bus.entry_lo1_o} !== 96'h0) begin
      fails++; $display("FAIL midrst_ignored_op got=%b/%h/%h/%h exp=1/0/0/0", bus.ent_we_o, bus.entry_hi_o,
                        bus.entry_lo0_o, bus.entry_lo1_o);
    end
    $display("test_reset_mid_op done");
  endtask

  initial begin
    bus.tlb_op_i = 3'd0;
    set_op_data(32'h0, 32'h0, 32'h0, 32'h0);
    bus.iaddr_i = 32'h0; bus.ireq_i = 1'b0;
    bus.daddr_i = 32'h0; bus.dreq_i = 1'b0; bus.dwe_i = 1'b0;
    test_reset();
    test_random_count();
    test_translate();
    test_probe();
    test_tlbr();
    test_store_protect();
    test_tlbwr();
    test_back_to_back();
    test_random_ops();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
